// File: rtl/ysyx_22050550_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050550_trap_ctrl
// Brief    : Trap sequencer for ecall/mret (and the optional machine timer
//            interrupt, enabled by ysyx_22050550_TIMERINT_EN). Writes
//            mepc/mcause/mstatus, flushes the pipeline and redirects fetch.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050550_trap_ctrl #(
    parameter int XLEN    = 64,
    parameter int CSREN_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_WB_valid,
    input  logic [XLEN-1:0]    io_WB_pc,
    input  logic [XLEN-1:0]    io_WB_NextPc,
    input  logic               io_WB_ecallflag,
    input  logic               io_WB_mretflag,
    output logic               io_TrapWB_ready,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    mepc,
    input  logic [XLEN-1:0]    mstatus,
    input  logic [XLEN-1:0]    mie,
    input  logic               io_irq_mtip,
    output logic [XLEN-1:0]    trapmepc,
    output logic [XLEN-1:0]    trapmcause,
    output logic [XLEN-1:0]    trapmstatus,
    output logic [CSREN_W-1:0] trapcsren,
    output logic               io_flush,
    output logic               io_redirect_valid,
    output logic [XLEN-1:0]    io_redirect_pc,
    input  logic               io_redirect_ready,
    output logic               io_busy
);

    localparam logic [CSREN_W-1:0] CSREN_TRAP  = CSREN_W'(8'h0B);
    localparam logic [CSREN_W-1:0] CSREN_MRET  = CSREN_W'(8'h08);
    localparam logic [XLEN-1:0]    CAUSE_ECALL = XLEN'(11);
    localparam logic [XLEN-1:0]    CAUSE_MTI   = {1'b1, (XLEN-1)'(7)};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SAVE     = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t               r_state;
    logic [XLEN-1:0]      r_target;
    logic [CSREN_W-1:0]   r_csren;
    logic [XLEN-1:0]      r_mepc;
    logic [XLEN-1:0]      r_mcause;
    logic [XLEN-1:0]      r_mstatus;
    logic                 r_flush;
    logic                 r_rvalid;
    logic [XLEN-1:0]      r_rpc;
    logic                 r_busy;
    logic                 r_ready;

    logic                 w_irq;
    logic                 w_unused_bits;
    logic [XLEN-1:0]      w_ms_entry;
    logic [XLEN-1:0]      w_ms_mret;
    logic [XLEN-1:0]      w_vector;

`ifdef ysyx_22050550_TIMERINT_EN
    assign w_irq         = io_irq_mtip & mie[7] & mstatus[3];
    assign w_unused_bits = ^{mtvec[1:0], mie[XLEN-1:8], mie[6:0]};
`else
    assign w_irq         = 1'b0;
    assign w_unused_bits = ^{mtvec[1:0], mie, io_irq_mtip, io_WB_NextPc};
`endif

    assign w_vector = {mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        w_ms_entry         = mstatus;
        w_ms_entry[7]      = mstatus[3];
        w_ms_entry[3]      = 1'b0;
        w_ms_entry[12:11]  = 2'b11;
        w_ms_mret          = mstatus;
        w_ms_mret[3]       = mstatus[7];
        w_ms_mret[7]       = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_target  <= '0;
            r_csren   <= '0;
            r_mepc    <= '0;
            r_mcause  <= '0;
            r_mstatus <= '0;
            r_flush   <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rpc     <= '0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_WB_valid && (io_WB_mretflag || io_WB_ecallflag || w_irq)) begin
                        r_state <= S_SAVE;
                        r_flush <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        if (io_WB_mretflag) begin
                            r_target  <= mepc;
                            r_csren   <= CSREN_MRET;
                            r_mepc    <= '0;
                            r_mcause  <= '0;
                            r_mstatus <= w_ms_mret;
                        end else if (io_WB_ecallflag) begin
                            r_target  <= w_vector;
                            r_csren   <= CSREN_TRAP;
                            r_mepc    <= io_WB_pc;
                            r_mcause  <= CAUSE_ECALL;
                            r_mstatus <= w_ms_entry;
                        end else begin
                            // Interrupted instruction still retires: resume after it.
                            r_target  <= w_vector;
                            r_csren   <= CSREN_TRAP;
                            r_mepc    <= io_WB_NextPc;
                            r_mcause  <= CAUSE_MTI;
                            r_mstatus <= w_ms_entry;
                        end
                    end
                end
                S_SAVE: begin
                    r_state   <= S_REDIRECT;
                    r_csren   <= '0;
                    r_mepc    <= '0;
                    r_mcause  <= '0;
                    r_mstatus <= '0;
                    r_flush   <= 1'b0;
                    r_rvalid  <= 1'b1;
                    r_rpc     <= r_target;
                end
                S_REDIRECT: begin
                    if (io_redirect_ready) begin
                        r_state  <= S_IDLE;
                        r_rvalid <= 1'b0;
                        r_rpc    <= '0;
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Reset forces reset values immediately so an aborted SAVE never writes CSRs.
    assign trapcsren         = reset ? '0 : r_csren;
    assign trapmepc          = reset ? '0 : r_mepc;
    assign trapmcause        = reset ? '0 : r_mcause;
    assign trapmstatus       = reset ? '0 : r_mstatus;
    assign io_flush          = ~reset & r_flush;
    assign io_redirect_valid = ~reset & r_rvalid;
    assign io_redirect_pc    = reset ? '0 : r_rpc;
    assign io_busy           = ~reset & r_busy;
    assign io_TrapWB_ready   = reset | r_ready;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050550_trap_ctrl.sv
`default_nettype none
// Testbench for ysyx_22050550_trap_ctrl: vector table plus scoreboard queues
// for the CSR-write and redirect phases.
module tb_ysyx_22050550_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_WB_valid = 1'b0;
    logic [63:0] io_WB_pc = '0;
    logic [63:0] io_WB_NextPc = '0;
    logic        io_WB_ecallflag = 1'b0;
    logic        io_WB_mretflag = 1'b0;
    logic        io_TrapWB_ready;
    logic [63:0] mtvec = '0, mepc = '0, mstatus = '0, mie = '0;
    logic        io_irq_mtip = 1'b0;
    logic [63:0] trapmepc, trapmcause, trapmstatus;
    logic [7:0]  trapcsren;
    logic        io_flush;
    logic        io_redirect_valid;
    logic [63:0] io_redirect_pc;
    logic        io_redirect_ready = 1'b1;
    logic        io_busy;

    ysyx_22050550_trap_ctrl #(.XLEN(64), .CSREN_W(8)) dut (
        .clock(clock), .reset(reset),
        .io_WB_valid(io_WB_valid), .io_WB_pc(io_WB_pc), .io_WB_NextPc(io_WB_NextPc),
        .io_WB_ecallflag(io_WB_ecallflag), .io_WB_mretflag(io_WB_mretflag),
        .io_TrapWB_ready(io_TrapWB_ready),
        .mtvec(mtvec), .mepc(mepc), .mstatus(mstatus), .mie(mie),
        .io_irq_mtip(io_irq_mtip),
        .trapmepc(trapmepc), .trapmcause(trapmcause), .trapmstatus(trapmstatus),
        .trapcsren(trapcsren), .io_flush(io_flush),
        .io_redirect_valid(io_redirect_valid), .io_redirect_pc(io_redirect_pc),
        .io_redirect_ready(io_redirect_ready), .io_busy(io_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ecall, mret, mtip, trap;
        logic [63:0] pc, npc, ms, tvec, epc, ie;
        logic [7:0]  csren;
        logic [63:0] emepc, emcause, ems, erpc;
    } vec_t;

    vec_t vecs[$];
    vec_t sq[$];
    vec_t rq[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    localparam logic [63:0] MTI = 64'h8000_0000_0000_0007;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ec, input logic mr, input logic tip,
                                input logic [63:0] pc, input logic [63:0] npc,
                                input logic [63:0] ms, input logic [63:0] tvec,
                                input logic [63:0] epc, input logic [63:0] ie,
                                input logic tr, input logic [7:0] ce,
                                input logic [63:0] emepc, input logic [63:0] emc,
                                input logic [63:0] ems, input logic [63:0] erpc);
        vec_t v;
        v.ecall = ec; v.mret = mr; v.mtip = tip; v.pc = pc; v.npc = npc;
        v.ms = ms; v.tvec = tvec; v.epc = epc; v.ie = ie; v.trap = tr;
        v.csren = ce; v.emepc = emepc; v.emcause = emc; v.ems = ems; v.erpc = erpc;
        return v;
    endfunction

    // Scoreboard side: CSR-write phase and redirect phase observed independently.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (trapcsren != 8'h0 || io_flush) begin
                if (sq.size() == 0) begin
                    chk("unexpected_csr_write", {56'h0, trapcsren}, 64'h0);
                end else begin
                    vec_t e;
                    e = sq.pop_front();
                    chk("csren", {56'h0, trapcsren}, {56'h0, e.csren});
                    chk("mepc", trapmepc, e.emepc);
                    chk("mcause", trapmcause, e.emcause);
                    chk("mstatus", trapmstatus, e.ems);
                    chk("flush", {63'h0, io_flush}, 64'h1);
                    chk("wb_ready_save", {63'h0, io_TrapWB_ready}, 64'h0);
                end
            end
            if (io_redirect_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_redirect", {63'h0, io_redirect_valid}, 64'h0);
                end else begin
                    chk("redirect_pc", io_redirect_pc, rq[0].erpc);
                    chk("wb_ready_redir", {63'h0, io_TrapWB_ready}, 64'h0);
                    chk("busy_redir", {63'h0, io_busy}, 64'h1);
                    if (io_redirect_ready) void'(rq.pop_front());
                end
            end
        end
    end

    task automatic clr();
        io_WB_valid = 1'b0;
        io_WB_ecallflag = 1'b0;
        io_WB_mretflag = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int stall, input bit junk);
        int cyc;
        @(posedge clock); #1;
        io_WB_valid = 1'b1; io_WB_ecallflag = v.ecall; io_WB_mretflag = v.mret;
        io_irq_mtip = v.mtip; io_WB_pc = v.pc; io_WB_NextPc = v.npc;
        mstatus = v.ms; mtvec = v.tvec; mepc = v.epc; mie = v.ie;
        if (stall > 0) io_redirect_ready = 1'b0;
        if (v.trap) begin
            sq.push_back(v);
            rq.push_back(v);
        end
        @(posedge clock); #1;
        if (junk) begin
            io_WB_ecallflag = 1'b1; io_WB_mretflag = 1'b0;
        end else begin
            clr();
        end
        if (!v.trap) begin
            @(negedge clock);
            chk("idle_flush", {63'h0, io_flush}, 64'h0);
            chk("idle_csren", {56'h0, trapcsren}, 64'h0);
            chk("idle_wb_ready", {63'h0, io_TrapWB_ready}, 64'h1);
        end else begin
            cyc = 0;
            do begin
                @(negedge clock);
                cyc++;
                if (junk && cyc == 1) begin
                    @(posedge clock); #1;
                    clr();
                end
                if (stall > 0 && cyc == 1 + stall) begin
                    @(posedge clock); #1;
                    io_redirect_ready = 1'b1;
                end
            end while (!io_TrapWB_ready && cyc < 30);
            chk("turnaround", 64'(cyc), 64'(3 + stall));
            chk("busy_after", {63'h0, io_busy}, 64'h0);
        end
    endtask

    initial begin
        vec_t v;
        vecs.push_back(mk(1, 0, 0, 64'h8000_0010, 64'h8000_0014, 64'h8, 64'h8000_1001, 0, 0,
                          1, 8'h0B, 64'h8000_0010, 64'hB, 64'h1880, 64'h8000_1000));
        vecs.push_back(mk(0, 1, 0, 64'h8000_0040, 64'h8000_0044, 64'h1880, 64'h8000_1000,
                          64'h8000_0014, 0, 1, 8'h08, 0, 0, 64'h1888, 64'h8000_0014));
`ifdef ysyx_22050550_TIMERINT_EN
        vecs.push_back(mk(0, 0, 1, 64'h8000_0020, 64'h8000_0024, 64'h8, 64'h8000_1000, 0, 64'h80,
                          1, 8'h0B, 64'h8000_0024, MTI, 64'h1880, 64'h8000_1000));
`else
        vecs.push_back(mk(0, 0, 1, 64'h8000_0020, 64'h8000_0024, 64'h8, 64'h8000_1000, 0, 64'h80,
                          0, 8'h00, 0, 0, 0, 0));
`endif
        vecs.push_back(mk(1, 0, 0, 64'h8000_0050, 64'h8000_0054, 64'h0, 64'h8000_2003, 0, 0,
                          1, 8'h0B, 64'h8000_0050, 64'hB, 64'h1800, 64'h8000_2000));
        vecs.push_back(mk(1, 1, 0, 64'h8000_0060, 64'h8000_0064, 64'h0, 64'h8000_1000,
                          64'h8000_0100, 0, 1, 8'h08, 0, 0, 64'h80, 64'h8000_0100));
        vecs.push_back(mk(1, 0, 1, 64'h8000_0070, 64'h8000_0074, 64'h8, 64'h8000_1000, 0, 64'h80,
                          1, 8'h0B, 64'h8000_0070, 64'hB, 64'h1880, 64'h8000_1000));
        vecs.push_back(mk(0, 0, 0, 64'h8000_0080, 64'h8000_0084, 64'h8, 64'h8000_1000, 0, 64'h80,
                          0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 64'h8000_0090, 64'h8000_0094, 64'hA000_0000_0000_0088,
                          64'h8000_1000, 0, 0, 1, 8'h0B, 64'h8000_0090, 64'hB,
                          64'hA000_0000_0000_1880, 64'h8000_1000));
        vecs.push_back(mk(0, 1, 0, 64'h8000_00A0, 64'h8000_00A4, 64'h0000_000F_0000_1000,
                          64'h8000_1000, 64'h8000_0200, 0, 1, 8'h08, 0, 0,
                          64'h0000_000F_0000_1080, 64'h8000_0200));

        // Reset state
        @(negedge clock);
        chk("rst_wb_ready", {63'h0, io_TrapWB_ready}, 64'h1);
        chk("rst_csren", {56'h0, trapcsren}, 64'h0);
        chk("rst_flush", {63'h0, io_flush}, 64'h0);
        chk("rst_rvalid", {63'h0, io_redirect_valid}, 64'h0);
        chk("rst_busy", {63'h0, io_busy}, 64'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i], 0, 1'b0);

        // Masked interrupt across 10 commits
        for (int k = 0; k < 10; k++) begin
            v = mk(0, 0, 1, 64'h8000_0300 + 64'(4 * k), 64'h8000_0304 + 64'(4 * k), 64'h0,
                   64'h8000_1000, 0, 64'h80, 0, 8'h00, 0, 0, 0, 0);
            apply_vec(v, 0, 1'b0);
        end

        // Backpressure with writeback traffic during SAVE that must be ignored
        apply_vec(vecs[0], 3, 1'b1);

        // Reset while in SAVE
        @(posedge clock); #1;
        io_WB_valid = 1'b1; io_WB_ecallflag = 1'b1; io_WB_pc = 64'h8000_0400;
        mstatus = 64'h8; mtvec = 64'h8000_1000;
        @(posedge clock); #1;
        clr();
        reset = 1'b1;
        @(negedge clock);
        chk("abort_csren", {56'h0, trapcsren}, 64'h0);
        chk("abort_flush", {63'h0, io_flush}, 64'h0);
        chk("abort_wb_ready", {63'h0, io_TrapWB_ready}, 64'h1);
        chk("abort_busy", {63'h0, io_busy}, 64'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("abort_no_redirect", {63'h0, io_redirect_valid}, 64'h0);
            chk("abort_idle", {63'h0, io_TrapWB_ready}, 64'h1);
        end

        chk("sq_drained", 64'(sq.size()), 64'h0);
        chk("rq_drained", 64'(rq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22050550_trap_ctrl.md
# ysyx_22050550_trap_ctrl

Trap sequencer that sits after the writeback stage and before the CSR file. It owns every trap-entry and trap-return CSR update: ecall, mret and, optionally, the machine timer interrupt. On a committing trap event it stalls writeback, flushes the pipeline, writes mepc/mcause/mstatus in one cycle, then redirects fetch to mtvec or mepc through a valid/ready handshake. In the top-level CSR write mux, its CSR enables take priority over the writeback unit's CSR enables.

## Interface
Parameters:
- XLEN, 64, data and CSR width
- CSREN_W, 8, CSR write-enable vector width (bit0 mepc, bit1 mcause, bit2 mtvec, bit3 mstatus, bit4 mie, bit5 mip)

Ports:
- clock  in  1  single clock; all state on posedge
- reset  in  1  synchronous, active-high
- io_WB_valid  in  1  writeback commit this cycle
- io_WB_pc  in  64  PC of the committing instruction
- io_WB_NextPc  in  64  architectural next PC of the committing instruction
- io_WB_ecallflag  in  1  committing instruction is ecall
- io_WB_mretflag  in  1  committing instruction is mret
- io_TrapWB_ready  out  1  writeback may commit; high only in IDLE
- mtvec, mepc, mstatus, mie  in  64  current CSR values
- io_irq_mtip  in  1  machine timer interrupt pending
- trapmepc, trapmcause, trapmstatus  out  64  CSR write data
- trapcsren  out  8  one-cycle CSR write enables
- io_flush  out  1  one-cycle pipeline flush
- io_redirect_valid  out  1  fetch redirect request
- io_redirect_pc  out  64  redirect target
- io_redirect_ready  in  1  fetch accepts the redirect
- io_busy  out  1  state != IDLE

## Operation
- States: IDLE, SAVE, REDIRECT.
- Event detection in IDLE happens only when io_WB_valid=1. Priority, highest first:
  - mret
  - ecall
  - interrupt: io_irq_mtip & mie[7] & mstatus[3]
  - no event: stay in IDLE
- On an event in cycle T, the block latches the event kind, pc, NextPc, mstatus, mtvec and mepc, then moves to SAVE.
- SAVE, one cycle:
  - io_flush=1.
  - ecall: trapcsren=8'h0B, trapmepc=latched pc, trapmcause=64'hB.
  - interrupt: trapcsren=8'h0B, trapmepc=latched NextPc (the instruction completes), trapmcause=64'h8000_0000_0000_0007.
  - Trap-entry mstatus (ecall and interrupt): MPIE(bit7)<=MIE(bit3), MIE<=0, MPP[12:11]<=2'b11, all other bits unchanged.
  - mret: trapcsren=8'h08. mstatus: MIE<=MPIE, MPIE<=1, MPP unchanged.
  - Next state: REDIRECT.
- REDIRECT:
  - io_redirect_valid=1.
  - io_redirect_pc = {latched mtvec[63:2], 2'b00} for a trap, or latched mepc for mret.
  - Holds until io_redirect_ready=1, then returns to IDLE the next cycle.
- Writeback inputs are ignored outside IDLE.
- Data outputs are 0 whenever their enable is 0.

## Timing
- Reset values: state IDLE, io_TrapWB_ready=1, every other output 0. Reset in SAVE or REDIRECT aborts the sequence with no CSR write; IDLE is reached the cycle after reset deasserts.
- Latency from commit (cycle T):
  - T+1: CSR write and flush.
  - T+2: first cycle of redirect_valid.
  - Minimum trap turnaround is 3 cycles.
- io_TrapWB_ready falls at T+1 and rises in the cycle after the redirect handshake.
- Redirect handshake:
  - valid stays high and pc stays stable under backpressure.
  - Completes in any cycle where valid & ready are both high.
  - Ready asserted early in SAVE has no effect.
- An interrupt that appears during SAVE or REDIRECT is sampled only at the next IDLE commit.
- An ecall clears MIE, so a simultaneous interrupt is naturally deferred until after the handler.

## Configuration
- ysyx_22050550_TIMERINT_EN defined: the interrupt path is compiled in as specified.
- Not defined: io_irq_mtip is still a port but is ignored. Only ecall and mret sequence, and mcause 0x8000_0000_0000_0007 is never produced.

## Test plan
- **Ecall entry.** ecall commit, pc=0x80000010, mstatus=0x8, mtvec=0x80001001.
  - T+1: trapcsren=0x0B, trapmepc=0x80000010, trapmcause=0xB, trapmstatus=0x1880, io_flush=1.
  - T+2: io_redirect_pc=0x80001000.
- **Mret.** mret commit, mepc=0x80000014, mstatus=0x1880.
  - T+1: trapcsren=0x08, trapmstatus=0x1888.
  - Redirect to 0x80000014.
- **Timer interrupt (macro on).** io_irq_mtip=1, mie=0x80, mstatus=0x8; plain commit with pc=0x80000020, NextPc=0x80000024.
  - trapmepc=0x80000024, trapmcause=0x8000000000000007, trapmstatus=0x1880.
- **Masked interrupt.** mstatus=0x0 (or macro off) with io_irq_mtip=1 across 10 commits.
  - No trapcsren, no flush, io_TrapWB_ready stays 1.
- **Backpressure.** io_redirect_ready held low for 3 cycles in REDIRECT.
  - valid and pc held stable, io_TrapWB_ready=0 throughout.
  - ready=1 on the 4th cycle gives IDLE on the following cycle.
- **Reset mid-sequence.** Reset asserted in SAVE.
  - trapcsren=0 in that cycle, all outputs at reset values, no redirect issued.
